affine_ctrl_vars_gen: RTL and testbench
=======================================

# affine_ctrl_vars_gen

Schedule-side driver for one unified-buffer port. Walks a 4-deep affine loop nest and, for each iteration, raises a one-cycle port enable (`_wen` or `_ren`) together with the matching `ctrl_vars[3:0]` loop indices. The buffer turns those indices into a RAM address. One instance sits beside each buffer port, e.g. hw_input writer, avg_pool reader/writer, hw_output reader.

## Interface
Parameters:
- `WIDTH`, 16: bit width of each ctrl_var and each internal counter.
- `EXTENT_0`, 1: trip count of loop 0 (outermost, root). Legal range 1..2^WIDTH-1.
- `EXTENT_1`, 4: trip count of loop 1 (channel).
- `EXTENT_2`, 32: trip count of loop 2 (row).
- `EXTENT_3`, 32: trip count of loop 3 (innermost, column).
- `START_DELAY`, 0: cycles from the flush edge to the first issue. Legal range 0..2^WIDTH-1.
- `II`, 1: initiation interval, in unstalled RUN cycles between issues. Must be ≥1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `flush`, input, 1: start or restart a run.
- `stall`, input, 1: freezes iteration progress.
- `en`, output, 1: issue strobe, wired to the buffer port's `_wen`/`_ren`.
- `ctrl_vars`, output, [WIDTH-1:0] x [3:0]: current loop indices, index 0 outermost.
- `done`, output, 1: the nest has completed.

## Operation
States:
- IDLE: reset state; no issues.
- DELAY: counting down the start delay.
- RUN: issuing iterations.
- DONE: nest complete.

Transitions:
- Reset (rst_n=0 at an edge) → IDLE. All counters cleared. `en`=0, `ctrl_vars`=0, `done`=0. Reset overrides flush.
- flush=1 from any state:
  - Loop counters, II counter and delay counter clear.
  - Next state is DELAY when START_DELAY>0, otherwise RUN.
  - `done` clears.
- DELAY: the delay counter increments every cycle; `stall` is ignored. The state moves to RUN on the edge where the count reaches START_DELAY-1.
- RUN:
  - `en` = (ii_cnt==0) && !stall. This output is combinational from registered state.
  - `ctrl_vars` always equals the registered loop counters.
  - ii_cnt advances on unstalled cycles and wraps from II-1 to 0. When stall=1, ii_cnt and the loop counters hold.
- Counter update on an issue: loop 3 increments. At EXTENT_3-1 it wraps to 0 and carries into loop 2, and so on up to loop 0. Any loop with EXTENT=1 stays at 0 and always carries.
- Final issue (all counters at EXTENT-1):
  - Counters wrap to 0.
  - Next state is DONE; `done`=1 from the following cycle and holds until flush or reset.
- DONE: `en`=0 and `ctrl_vars`=0.
- Total `en` pulses per run = EXTENT_0·EXTENT_1·EXTENT_2·EXTENT_3. Counters never exceed EXTENT-1.

## Timing
- The flush sampled at edge t gives the first `en` in the cycle after edge t+START_DELAY, with `ctrl_vars`=0.
  - Example: START_DELAY=0 → `en` high in cycle t+1.
- With II=1 and no stall, issues are back-to-back.
- With II=k, issues come every k unstalled RUN cycles. A stall delays the pending issue cycle for cycle.
- flush arriving on the same edge as the final issue: the flush wins, no DONE, and the run restarts.
- flush mid-RUN: `en`=0 in the next cycle unless START_DELAY=0, in which case a new issue with `ctrl_vars`=0 follows immediately.
- Reset mid-run: outputs are 0 from the cycle after the reset edge.

## Configuration
- `AFFINE_CTRL_VARS_GEN_AUTO_RESTART_EN`
  - Defined: the final issue re-enters DELAY (START_DELAY>0) or RUN (START_DELAY=0) instead of DONE. `done` pulses for exactly one cycle per completed nest, and runs repeat until reset.
  - Undefined: the DONE behaviour above applies.

## Test plan
- Defaults, flush at cycle 0, no stall → exactly 4096 consecutive `en` in cycles 1..4096.
  - Pulse 1: `ctrl_vars`={0,0,0,0}.
  - Pulse 33: {0,0,1,0}.
  - Pulse 1025: {0,1,0,0}.
  - Last pulse: {0,3,31,31}.
  - `done`=1 from cycle 4097 and held through cycle 4200.
- EXTENTS 1,1,2,3, II=2, START_DELAY=3, flush at cycle 0 → `en` in cycles 4,6,8,10,12,14 with ctrl_vars[3:2] = 0/0, 1/0, 2/0, 0/1, 1/1, 2/1; `done` at cycle 15.
- Defaults, stall=1 in cycles 5–7 → pulses 1–4 in cycles 1–4, then no `en` in cycles 5–7; pulse 5 (ctrl_vars[3]=4) in cycle 8; last pulse in cycle 4099.
- Defaults, second flush at cycle 100 → pulse 100 is ctrl_vars[3]=3/ctrl_vars[2]=3; cycle 101 restarts at {0,0,0,0}; 4096 further pulses follow.
- rst_n=0 at cycle 50 during a run → `en`, `ctrl_vars` and `done` all 0 from cycle 51. A flush at cycle 50 is ignored.
- With the macro defined, EXTENTS 1,1,1,4, flush at 0 → `en` continuous from cycle 1; `done` pulses in cycles 5, 9, 13; `ctrl_vars[3]` cycles 0,1,2,3.

Source files
------------

// File: rtl/affine_ctrl_vars_gen_if.sv
// affine_ctrl_vars_gen_if: schedule-side port bundle between an affine driver and its buffer port.
`timescale 1ns/1ps
interface affine_ctrl_vars_gen_if #(
   parameter int WIDTH = 16
);
   logic                  flush;
   logic                  stall;
   logic                  en;
   logic [3:0][WIDTH-1:0] ctrl_vars;
   logic                  done;
   modport master (input flush, stall, output en, ctrl_vars, done);
   modport slave (output flush, stall, input en, ctrl_vars, done);
endinterface

// File: rtl/affine_ctrl_vars_gen.sv
// affine_ctrl_vars_gen: walks a 4-deep affine loop nest, issuing one en strobe plus loop indices per iteration.
// Optional AFFINE_CTRL_VARS_GEN_AUTO_RESTART_EN: restart after each nest with a one-cycle done pulse.
`timescale 1ns/1ps
module affine_ctrl_vars_gen #(
   parameter int WIDTH       = 16,
   parameter int EXTENT_0    = 1,
   parameter int EXTENT_1    = 4,
   parameter int EXTENT_2    = 32,
   parameter int EXTENT_3    = 32,
   parameter int START_DELAY = 0,
   parameter int II          = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   affine_ctrl_vars_gen_if.master sched
);
   typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_e;
   localparam logic [3:0][WIDTH-1:0] EXT_M1 = {WIDTH'(EXTENT_3 - 1), WIDTH'(EXTENT_2 - 1),
                                               WIDTH'(EXTENT_1 - 1), WIDTH'(EXTENT_0 - 1)};
   localparam logic [WIDTH-1:0] DLY_M1 = WIDTH'(START_DELAY - 1);
   localparam logic [WIDTH-1:0] II_M1 = WIDTH'(II - 1);
   localparam state_e START_ST = (START_DELAY > 0) ? DELAY : RUN;
   state_e                state_q, state_d;
   logic [3:0][WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
   logic [WIDTH-1:0]      ii_q, ii_d, dly_q, dly_d;
   logic                  done_q, done_d, issue, carry, last;
   assign issue = state_q == RUN && ii_q == '0 && !sched.stall;
   // Mixed-radix increment, innermost loop 3 first; carry out of loop 0 marks the final issue.
   always_comb begin
      carry = 1'b1;
      cnt_nxt = cnt_q;
      for (int i = 3; i >= 0; i--) begin
         if (carry) cnt_nxt[i] = (cnt_q[i] == EXT_M1[i]) ? '0 : cnt_q[i] + 1'b1;
         carry = carry && cnt_q[i] == EXT_M1[i];
      end
      last = carry;
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ii_d = ii_q;
      dly_d = dly_q;
`ifdef AFFINE_CTRL_VARS_GEN_AUTO_RESTART_EN
      done_d = 1'b0;
`else
      done_d = done_q;
`endif
      if (sched.flush) begin
         state_d = START_ST;
         cnt_d = '0;
         ii_d = '0;
         dly_d = '0;
         done_d = 1'b0;
      end else if (state_q == DELAY) begin
         dly_d = dly_q + 1'b1;
         state_d = (dly_q == DLY_M1) ? RUN : DELAY;
      end else if (state_q == RUN && !sched.stall) begin
         ii_d = (ii_q == II_M1) ? '0 : ii_q + 1'b1;
         if (issue) cnt_d = cnt_nxt;
         if (issue && last) begin
            ii_d = '0;
            dly_d = '0;
            done_d = 1'b1;
`ifdef AFFINE_CTRL_VARS_GEN_AUTO_RESTART_EN
            state_d = START_ST;
`else
            state_d = DONE;
`endif
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ii_q <= '0;
         dly_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ii_q <= ii_d;
         dly_q <= dly_d;
         done_q <= done_d;
      end
   end
   assign sched.en = issue;
   assign sched.ctrl_vars = cnt_q;
   assign sched.done = done_q;
endmodule

// File: tb/tb_affine_ctrl_vars_gen.sv
// tb_affine_ctrl_vars_gen: scoreboard bench for affine_ctrl_vars_gen (three parameterisations).
`timescale 1ns/1ps
module tb_affine_ctrl_vars_gen;
   typedef struct {
      int          cyc;
      logic [63:0] cv;
   } exp_t;
   logic clk = 1'b0;
   logic ra, rb, rc;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   base[3] = '{0, 0, 0};
   exp_t q[3][$];
   affine_ctrl_vars_gen_if #(.WIDTH(16)) a_if ();
   affine_ctrl_vars_gen_if #(.WIDTH(16)) b_if ();
   affine_ctrl_vars_gen_if #(.WIDTH(16)) c_if ();
   affine_ctrl_vars_gen dut_a (.clk(clk), .rst_n(ra), .sched(a_if));
   affine_ctrl_vars_gen #(.EXTENT_0(1), .EXTENT_1(1), .EXTENT_2(2), .EXTENT_3(3), .START_DELAY(3), .II(2))
      dut_b (.clk(clk), .rst_n(rb), .sched(b_if));
   affine_ctrl_vars_gen #(.EXTENT_0(1), .EXTENT_1(1), .EXTENT_2(1), .EXTENT_3(4))
      dut_c (.clk(clk), .rst_n(rc), .sched(c_if));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask
   // Expected indices of issue n by mixed-radix decomposition (index 0 outermost).
   function automatic logic [63:0] exp_cv(input int n, input int e1, input int e2, input int e3);
      logic [3:0][15:0] v;
      v[3] = 16'(n % e3);
      v[2] = 16'((n / e3) % e2);
      v[1] = 16'((n / (e3 * e2)) % e1);
      v[0] = 16'(n / (e3 * e2 * e1));
      return v;
   endfunction
   task automatic push_run(input int d, input int start, input int ii, input int cnt, input int e1,
                           input int e2, input int e3, input int sfrom, input int slen);
      int c;
      for (int n = 0; n < cnt; n++) begin
         c = start + n * ii;
         if (slen > 0 && c >= sfrom) c += slen;
         q[d].push_back('{c, exp_cv(n, e1, e2, e3)});
      end
   endtask
   task automatic mon(input int d, input logic en, input logic [63:0] cv);
      exp_t e;
      int   rel;
      rel = cyc - base[d];
      if (en) begin
         if (q[d].size() == 0) chk($sformatf("d%0d_unexpected_en_c%0d", d, rel), 64'(en), 64'd0);
         else begin
            e = q[d].pop_front();
            chk($sformatf("d%0d_en_cycle", d), 64'(rel), 64'(e.cyc));
            chk($sformatf("d%0d_ctrl_vars_c%0d", d, rel), cv, e.cv);
         end
      end else if (q[d].size() != 0 && q[d][0].cyc <= rel) begin
         e = q[d].pop_front();
         chk($sformatf("d%0d_missing_en_c%0d", d, e.cyc), 64'(en), 64'd1);
      end
   endtask
   always @(negedge clk) begin
      #1;
      mon(0, a_if.en, a_if.ctrl_vars);
      mon(1, b_if.en, b_if.ctrl_vars);
      mon(2, c_if.en, c_if.ctrl_vars);
   end
   task automatic go_to(input int d, input int n);
      do @(negedge clk); while (cyc - base[d] < n);
   endtask
   task automatic start_a;
      @(negedge clk);
      base[0] = cyc;
      a_if.flush = 1'b1;
   endtask
   initial begin
      {ra, rb, rc} = 3'b000;
      {a_if.flush, a_if.stall, b_if.flush, b_if.stall, c_if.flush, c_if.stall} = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_a_en", 64'(a_if.en), 0);
      chk("rst_a_cv", a_if.ctrl_vars, 0);
      chk("rst_a_done", 64'(a_if.done), 0);
      chk("rst_b_en", 64'(b_if.en), 0);
      chk("rst_b_done", 64'(b_if.done), 0);
      chk("rst_c_done", 64'(c_if.done), 0);
      {ra, rb, rc} = 3'b111;
      // DUT B: delay 3, II 2, extents 1,1,2,3
      @(negedge clk);
      base[1] = cyc;
      b_if.flush = 1'b1;
      push_run(1, 4, 2, 6, 1, 2, 3, 0, 0);
      @(negedge clk);
      b_if.flush = 1'b0;
      go_to(1, 14); #1;
      chk("b_done_c14", 64'(b_if.done), 0);
      go_to(1, 15); #1;
      chk("b_done_c15", 64'(b_if.done), 1);
      chk("b_cv_done", b_if.ctrl_vars, 0);
      chk("b_all_issued", 64'(q[1].size()), 0);
      // DUT C: extents 1,1,1,4
      @(negedge clk);
      base[2] = cyc;
      c_if.flush = 1'b1;
`ifdef AFFINE_CTRL_VARS_GEN_AUTO_RESTART_EN
      push_run(2, 1, 1, 20, 1, 1, 4, 0, 0);
      @(negedge clk);
      c_if.flush = 1'b0;
      go_to(2, 4); #1; chk("c_done_c4", 64'(c_if.done), 0);
      go_to(2, 5); #1; chk("c_done_c5", 64'(c_if.done), 1);
      go_to(2, 6); #1; chk("c_done_c6", 64'(c_if.done), 0);
      go_to(2, 9); #1; chk("c_done_c9", 64'(c_if.done), 1);
      go_to(2, 13); #1; chk("c_done_c13", 64'(c_if.done), 1);
      go_to(2, 20);
      rc = 1'b0;
      go_to(2, 21);
      rc = 1'b1;
`else
      push_run(2, 1, 1, 4, 1, 1, 4, 0, 0);
      @(negedge clk);
      c_if.flush = 1'b0;
      go_to(2, 4); #1; chk("c_done_c4", 64'(c_if.done), 0);
      go_to(2, 5); #1; chk("c_done_c5", 64'(c_if.done), 1);
      go_to(2, 9); #1; chk("c_done_c9", 64'(c_if.done), 1);
`endif
      #1 chk("c_all_issued", 64'(q[2].size()), 0);
      // DUT A test 1: full default run
      start_a();
      push_run(0, 1, 1, 4096, 4, 32, 32, 0, 0);
      @(negedge clk);
      a_if.flush = 1'b0;
      go_to(0, 4096); #1; chk("a1_done_c4096", 64'(a_if.done), 0);
      go_to(0, 4097); #1; chk("a1_done_c4097", 64'(a_if.done), 1);
      go_to(0, 4200); #1;
      chk("a1_done_c4200", 64'(a_if.done), 1);
      chk("a1_cv_c4200", a_if.ctrl_vars, 0);
      chk("a1_all_issued", 64'(q[0].size()), 0);
      // test 2: stall in cycles 5..7
      start_a();
      push_run(0, 1, 1, 4096, 4, 32, 32, 5, 3);
      @(negedge clk);
      a_if.flush = 1'b0;
      #1 chk("a2_done_cleared", 64'(a_if.done), 0);
      go_to(0, 5);
      a_if.stall = 1'b1;
      go_to(0, 8);
      a_if.stall = 1'b0;
      go_to(0, 4099); #1; chk("a2_done_c4099", 64'(a_if.done), 0);
      go_to(0, 4100); #1; chk("a2_done_c4100", 64'(a_if.done), 1);
      chk("a2_all_issued", 64'(q[0].size()), 0);
      // test 3: re-flush at cycle 100
      start_a();
      push_run(0, 1, 1, 100, 4, 32, 32, 0, 0);
      push_run(0, 101, 1, 4096, 4, 32, 32, 0, 0);
      @(negedge clk);
      a_if.flush = 1'b0;
      go_to(0, 100);
      a_if.flush = 1'b1;
      go_to(0, 101);
      a_if.flush = 1'b0;
      go_to(0, 4196); #1; chk("a3_done_c4196", 64'(a_if.done), 0);
      go_to(0, 4197); #1; chk("a3_done_c4197", 64'(a_if.done), 1);
      chk("a3_all_issued", 64'(q[0].size()), 0);
      // test 4: reset plus flush at cycle 50
      start_a();
      push_run(0, 1, 1, 50, 4, 32, 32, 0, 0);
      @(negedge clk);
      a_if.flush = 1'b0;
      go_to(0, 50);
      ra = 1'b0;
      a_if.flush = 1'b1;
      go_to(0, 51); #1;
      chk("a4_en_c51", 64'(a_if.en), 0);
      chk("a4_cv_c51", a_if.ctrl_vars, 0);
      chk("a4_done_c51", 64'(a_if.done), 0);
      ra = 1'b1;
      a_if.flush = 1'b0;
      go_to(0, 60); #1;
      chk("a4_en_c60", 64'(a_if.en), 0);
      chk("a4_all_issued", 64'(q[0].size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
